// File: rtl/ysyx_22040759_ifu_pkg.sv
// IFU shared definitions: FSM state encodings, default reset PC, instruction width.
// No latency or backpressure of its own; imported by ysyx_22040759_ifu.
package ysyx_22040759_ifu_pkg;

  localparam int          INST_W       = 32;
  localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    ifu_idle = 2'd0,
    ifu_req  = 2'd1,
    ifu_wait = 2'd2,
    ifu_hold = 2'd3
  } ifu_state_e;

  function automatic logic [63:0] seq_pc(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/ysyx_22040759_ifu.sv
// Fetch unit: one outstanding imem request, one-entry output buffer, redirect flushes in-flight fetch.
// Latency REQ->WAIT->HOLD (3 cycles/inst at zero wait); HOLD stalls until if_ready, REQ until imem_req_ready.
// YSYX_22040759_IFU_PERF_EN adds perf_fetch_cnt / perf_drop_cnt outputs.
module ysyx_22040759_ifu
  import ysyx_22040759_ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = IFU_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_taken,
  input  logic [63:0]       blu_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [63:0]       imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [63:0]       if_pc,
  output logic [INST_W-1:0] if_inst
`ifdef YSYX_22040759_IFU_PERF_EN
  ,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_drop_cnt
`endif
);

  ifu_state_e        state_q, state_d;
  logic [63:0]       pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              req_vld_q, req_vld_d;
  logic              if_vld_q, if_vld_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    case (state_q)
      ifu_idle: state_d = ifu_req;
      ifu_req: begin
        if (br_taken) pc_d = blu_pc;
        if (imem_req_ready) begin
          state_d = ifu_wait;
          drop_d  = br_taken;
        end
      end
      ifu_wait: begin
        if (imem_rsp_valid) begin
          // A redirect before or with the response makes it stale.
          if (drop_q || br_taken) begin
            drop_d  = 1'b0;
            state_d = ifu_req;
            if (br_taken) pc_d = blu_pc;
          end else begin
            inst_d  = imem_rsp_data;
            state_d = ifu_hold;
          end
        end else if (br_taken) begin
          pc_d   = blu_pc;
          drop_d = 1'b1;
        end
      end
      ifu_hold: begin
        if (br_taken) begin
          pc_d    = blu_pc;
          state_d = ifu_req;
        end else if (if_ready) begin
          pc_d    = seq_pc(pc_q);
          state_d = ifu_req;
        end
      end
      default: state_d = ifu_idle;
    endcase
    req_vld_d = (state_d == ifu_req);
    if_vld_d  = (state_d == ifu_hold);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ifu_idle;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      inst_q    <= '0;
      req_vld_q <= 1'b0;
      if_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      inst_q    <= inst_d;
      req_vld_q <= req_vld_d;
      if_vld_q  <= if_vld_d;
    end
  end

  assign imem_req_valid = req_vld_q;
  assign imem_req_addr  = pc_q;
  assign if_valid       = if_vld_q;
  assign if_pc          = pc_q;
  assign if_inst        = inst_q;

`ifdef YSYX_22040759_IFU_PERF_EN
  logic [63:0] perf_fetch_q, perf_fetch_d;
  logic [63:0] perf_drop_q, perf_drop_d;
  logic        fetch_evt, drop_evt;

  always_comb begin
    fetch_evt    = (state_q == ifu_hold) && if_ready && !br_taken;
    drop_evt     = (state_q == ifu_wait) && imem_rsp_valid && (drop_q || br_taken);
    perf_fetch_d = perf_fetch_q + {63'd0, fetch_evt};
    perf_drop_d  = perf_drop_q + {63'd0, drop_evt};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_drop_q  <= perf_drop_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_drop_cnt  = perf_drop_q;
`else
  // Counters are compiled out; fetch behaviour is unaffected.
`endif

endmodule

// File: tb/tb_ysyx_22040759_ifu.sv
// Bench for ysyx_22040759_ifu: memory model plus request/fetch scoreboards.
module tb_ysyx_22040759_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br_taken = 1'b0;
  logic [63:0] blu_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [63:0] if_pc;
  logic [31:0] if_inst;

  logic        w_req_valid;
  logic        w_req_ready = 1'b0;
  logic [63:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = '0;
  logic        w_if_valid;
  logic        w_if_ready = 1'b0;
  logic [63:0] w_if_pc;
  logic [31:0] w_if_inst;

`ifdef YSYX_22040759_IFU_PERF_EN
  logic [63:0] perf_fetch_cnt, perf_drop_cnt, w_perf_fetch_cnt, w_perf_drop_cnt;
`endif

  always #5 clk = ~clk;

  ysyx_22040759_ifu u_dut (
    .clk(clk), .rst(rst), .br_taken(br_taken), .blu_pc(blu_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst)
`ifdef YSYX_22040759_IFU_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
  );

  ysyx_22040759_ifu #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst(rst), .br_taken(1'b0), .blu_pc(64'd0),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .if_valid(w_if_valid), .if_ready(w_if_ready), .if_pc(w_if_pc), .if_inst(w_if_inst)
`ifdef YSYX_22040759_IFU_PERF_EN
    , .perf_fetch_cnt(w_perf_fetch_cnt), .perf_drop_cnt(w_perf_drop_cnt)
`endif
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fetch_t;

  logic [63:0] exp_req_q[$];
  fetch_t      exp_if_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  bit          mem_ready = 1'b0;
  int          rsp_lat = 1;
  int          pend_cnt = 0;
  logic [63:0] pend_addr = '0;
  bit          br_next = 1'b0;
  logic [63:0] blu_next = '0;
  bit          dec_ready = 1'b0;
  bit          fire = 1'b0;
  bit          rsp_now = 1'b0;
  logic [63:0] rsp_addr = '0;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0013;
  endfunction

  // One cycle: at the falling edge drive memory/decode/branch inputs for the next rising edge.
  task automatic step();
    @(negedge clk);
    rsp_now = 1'b0;
    imem_rsp_valid = 1'b0;
    if (pend_cnt == 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(pend_addr);
      rsp_now  = 1'b1;
      rsp_addr = pend_addr;
    end
    if (pend_cnt > 0) pend_cnt--;
    imem_req_ready = mem_ready;
    br_taken = br_next;
    blu_pc   = blu_next;
    br_next  = 1'b0;
    if_ready = dec_ready;
    fire = imem_req_valid && imem_req_ready;
    if (fire) begin
      pend_cnt  = rsp_lat;
      pend_addr = imem_req_addr;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; dec_ready = 1'b1;
    step(); step();
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    n_checks++; if (imem_req_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL rst_req_addr: got %h want 80000000", imem_req_addr); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_if_valid: got %b want 0", if_valid); end
    n_checks++; if (if_pc !== 64'h8000_0000) begin n_fail++; $display("FAIL rst_if_pc: got %h want 80000000", if_pc); end
    n_checks++; if (if_inst !== 32'h0) begin n_fail++; $display("FAIL rst_if_inst: got %h want 0", if_inst); end
`ifdef YSYX_22040759_IFU_PERF_EN
    n_checks++; if (perf_fetch_cnt !== 64'd0 || perf_drop_cnt !== 64'd0) begin n_fail++; $display("FAIL rst_perf: got %0d/%0d want 0/0", perf_fetch_cnt, perf_drop_cnt); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_stream();
    int last_if = -1;
    fetch_t e;
    exp_req_q.push_back(64'h8000_0000);
    exp_req_q.push_back(64'h8000_0004);
    exp_req_q.push_back(64'h8000_0008);
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1) begin
        n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req_cycle1: got %b want 1", imem_req_valid); end
      end
      if (fire) begin
        n_checks++;
        if (exp_req_q.size() == 0) begin n_fail++; $display("FAIL stream_req: unexpected request to %h", imem_req_addr); end
        else if (imem_req_addr !== exp_req_q[0]) begin n_fail++; $display("FAIL stream_req: got %h want %h", imem_req_addr, exp_req_q[0]); void'(exp_req_q.pop_front()); end
        else void'(exp_req_q.pop_front());
      end
      if (rsp_now) exp_if_q.push_back('{pc: rsp_addr, inst: inst_of(rsp_addr)});
      if (if_valid) begin
        n_checks++;
        if (exp_if_q.size() == 0) begin n_fail++; $display("FAIL stream_if: unexpected if_valid pc %h", if_pc); end
        else begin
          e = exp_if_q.pop_front();
          if (if_pc !== e.pc || if_inst !== e.inst) begin n_fail++; $display("FAIL stream_if: got %h/%h want %h/%h", if_pc, if_inst, e.pc, e.inst); end
        end
        if (last_if >= 0) begin
          n_checks++; if (c - last_if != 3) begin n_fail++; $display("FAIL stream_period: got %0d want 3", c - last_if); end
        end
        last_if = c;
      end
    end
    n_checks++; if (exp_req_q.size() != 0) begin n_fail++; $display("FAIL stream_req_count: got %0d left want 0", exp_req_q.size()); end
  endtask

  task automatic test_stall();
    fetch_t e;
    int guard = 0;
    exp_req_q.push_back(64'h8000_000C);
    dec_ready = 1'b0;
    do begin
      step();
      guard++;
      if (fire) begin
        n_checks++;
        if (exp_req_q.size() == 0 || imem_req_addr !== exp_req_q[0]) begin n_fail++; $display("FAIL stall_req: got %h", imem_req_addr); end
        if (exp_req_q.size() != 0) void'(exp_req_q.pop_front());
      end
      if (rsp_now) exp_if_q.push_back('{pc: rsp_addr, inst: inst_of(rsp_addr)});
    end while (!if_valid && guard < 10);
    n_checks++;
    if (!if_valid || exp_if_q.size() == 0) begin
      n_fail++; $display("FAIL stall_timeout: if_valid %b after %0d cycles want 1", if_valid, guard);
    end else begin
      e = exp_if_q[0];
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== e.pc || if_inst !== e.inst || imem_req_valid !== 1'b0) begin
          n_fail++; $display("FAIL stall_hold[%0d]: got v%b %h/%h req%b want v1 %h/%h req0", k, if_valid, if_pc, if_inst, imem_req_valid, e.pc, e.inst);
        end
        if (k < 4) step();
      end
      dec_ready = 1'b1;
      step();
      e = exp_if_q.pop_front();
      n_checks++; if (!(if_valid && if_ready) || if_pc !== e.pc) begin n_fail++; $display("FAIL stall_release: got v%b pc %h want v1 pc %h", if_valid, if_pc, e.pc); end
    end
  endtask

  task automatic test_redirect_wait();
    fetch_t e;
    exp_req_q.push_back(64'h8000_0010);
    rsp_lat = 3; dec_ready = 1'b1;
    step();
    n_checks++;
    if (!fire || exp_req_q.size() == 0 || imem_req_addr !== exp_req_q[0]) begin n_fail++; $display("FAIL rw_req: got fire%b %h want 80000010", fire, imem_req_addr); end
    if (exp_req_q.size() != 0) void'(exp_req_q.pop_front());
    br_next = 1'b1; blu_next = 64'h8000_1000;
    step();
    rsp_lat = 1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL rw_wait_stale[%0d]: got req%b if%b want 0/0", k, imem_req_valid, if_valid); end
    end
    exp_req_q.push_back(64'h8000_1000);
    step();
    n_checks++;
    if (!fire || imem_req_addr !== exp_req_q[0]) begin n_fail++; $display("FAIL rw_redirect_req: got fire%b %h want 80001000", fire, imem_req_addr); end
    void'(exp_req_q.pop_front());
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rw_discard: got if_valid %b want 0", if_valid); end
`ifdef YSYX_22040759_IFU_PERF_EN
    n_checks++; if (perf_drop_cnt !== 64'd1) begin n_fail++; $display("FAIL rw_perf_drop: got %0d want 1", perf_drop_cnt); end
`endif
    step();
    if (rsp_now) exp_if_q.push_back('{pc: rsp_addr, inst: inst_of(rsp_addr)});
    step();
    n_checks++;
    if (exp_if_q.size() == 0) begin n_fail++; $display("FAIL rw_fetch: no response queued"); end
    else begin
      e = exp_if_q.pop_front();
      if (if_valid !== 1'b1 || if_pc !== e.pc || if_inst !== e.inst) begin n_fail++; $display("FAIL rw_fetch: got v%b %h/%h want v1 %h/%h", if_valid, if_pc, if_inst, e.pc, e.inst); end
    end
  endtask

  task automatic test_redirect_hold();
    fetch_t e;
    exp_req_q.push_back(64'h8000_1004);
    step();
    n_checks++;
    if (!fire || imem_req_addr !== exp_req_q[0]) begin n_fail++; $display("FAIL rh_req: got fire%b %h want 80001004", fire, imem_req_addr); end
    void'(exp_req_q.pop_front());
    step();
    if (rsp_now) exp_if_q.push_back('{pc: rsp_addr, inst: inst_of(rsp_addr)});
    br_next = 1'b1; blu_next = 64'h8000_0400;
    step();
    n_checks++;
    if (exp_if_q.size() == 0) begin n_fail++; $display("FAIL rh_present: no response queued"); end
    else begin
      e = exp_if_q.pop_front();
      if (if_valid !== 1'b1 || if_pc !== e.pc) begin n_fail++; $display("FAIL rh_present: got v%b %h want v1 %h", if_valid, if_pc, e.pc); end
    end
    mem_ready = 1'b0;
    step();
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0400) begin n_fail++; $display("FAIL rh_target: got v%b %h want v1 80000400", imem_req_valid, imem_req_addr); end
`ifdef YSYX_22040759_IFU_PERF_EN
    n_checks++; if (perf_fetch_cnt !== 64'd5) begin n_fail++; $display("FAIL rh_perf_fetch: got %0d want 5", perf_fetch_cnt); end
`endif
  endtask

  task automatic test_redirect_req();
    fetch_t e;
    br_next = 1'b1; blu_next = 64'h8000_0200;
    step();
    n_checks++; if (imem_req_addr !== 64'h8000_0400) begin n_fail++; $display("FAIL rq_before: got %h want 80000400", imem_req_addr); end
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0200) begin n_fail++; $display("FAIL rq_switch[%0d]: got v%b %h want v1 80000200", k, imem_req_valid, imem_req_addr); end
    end
    exp_req_q.push_back(64'h8000_0200);
    mem_ready = 1'b1;
    step();
    n_checks++;
    if (!fire || imem_req_addr !== exp_req_q[0]) begin n_fail++; $display("FAIL rq_accept: got fire%b %h want 80000200", fire, imem_req_addr); end
    void'(exp_req_q.pop_front());
    step();
    if (rsp_now) exp_if_q.push_back('{pc: rsp_addr, inst: inst_of(rsp_addr)});
    step();
    n_checks++;
    if (exp_if_q.size() == 0) begin n_fail++; $display("FAIL rq_fetch: no response queued"); end
    else begin
      e = exp_if_q.pop_front();
      if (if_valid !== 1'b1 || if_pc !== e.pc || if_inst !== e.inst) begin n_fail++; $display("FAIL rq_fetch: got v%b %h/%h want v1 %h/%h", if_valid, if_pc, if_inst, e.pc, e.inst); end
    end
`ifdef YSYX_22040759_IFU_PERF_EN
    n_checks++; if (perf_drop_cnt !== 64'd1) begin n_fail++; $display("FAIL rq_perf_drop: got %0d want 1", perf_drop_cnt); end
`endif
  endtask

  task automatic test_reset_midfetch();
    exp_req_q.push_back(64'h8000_0204);
    step();
    n_checks++;
    if (!fire || imem_req_addr !== exp_req_q[0]) begin n_fail++; $display("FAIL rm_req: got fire%b %h want 80000204", fire, imem_req_addr); end
    void'(exp_req_q.pop_front());
    step();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== 64'h8000_0000 || if_valid !== 1'b0 || if_pc !== 64'h8000_0000 || if_inst !== 32'h0) begin
      n_fail++; $display("FAIL rm_async: got req%b %h if%b %h/%h want 0 80000000 0 80000000/0", imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst);
    end
`ifdef YSYX_22040759_IFU_PERF_EN
    n_checks++; if (perf_fetch_cnt !== 64'd0 || perf_drop_cnt !== 64'd0) begin n_fail++; $display("FAIL rm_perf: got %0d/%0d want 0/0", perf_fetch_cnt, perf_drop_cnt); end
`endif
    pend_cnt = 0; mem_ready = 1'b0;
    exp_req_q.delete(); exp_if_q.delete();
    step();
    rst = 1'b0;
    step();
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL rm_restart: got v%b %h want v1 80000000", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_wrap();
    logic [31:0] w_data = 32'h0010_0073;
    @(negedge clk);
    n_checks++; if (w_req_valid !== 1'b1 || w_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_first: got v%b %h want v1 fffffffffffffffc", w_req_valid, w_req_addr); end
    w_req_ready = 1'b1;
    @(negedge clk);
    w_req_ready = 1'b0; w_rsp_valid = 1'b1; w_rsp_data = w_data;
    @(negedge clk);
    w_rsp_valid = 1'b0;
    n_checks++; if (w_if_valid !== 1'b1 || w_if_pc !== 64'hFFFF_FFFF_FFFF_FFFC || w_if_inst !== w_data) begin n_fail++; $display("FAIL wrap_hold: got v%b %h/%h want v1 fffffffffffffffc/%h", w_if_valid, w_if_pc, w_if_inst, w_data); end
    w_if_ready = 1'b1;
    @(negedge clk);
    w_if_ready = 1'b0;
    n_checks++; if (w_req_valid !== 1'b1 || w_req_addr !== 64'h0) begin n_fail++; $display("FAIL wrap_next: got v%b %h want v1 0", w_req_valid, w_req_addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_redirect_req();
    test_reset_midfetch();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
